// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_core transmitter among NREQ byte sources.
// Optional UART_SCHED_PRIO0_EN: requester 0 gets strict priority over the round-robin group.
module uart_tx_sched #(
   parameter int NREQ        = 4,
   parameter int GAP_CYC     = 2,
   parameter int ACK_TIMEOUT = 8,
   parameter int IDW         = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        core_tx_data,
   output logic              core_tx_req,
   input  logic              core_tx_busy,
   output logic              grant_active,
   output logic [IDW-1:0]    grant_id,
   output logic              err_noack,
   input  logic              err_clr
);

   // state     | meaning
   // S_IDLE    | waiting for a valid requester with the core idle
   // S_ISSUE   | one-cycle tx_req strobe and ready pulse to the winner
   // S_WAIT_BUSY | waiting for the core to acknowledge with tx_busy
   // S_WAIT_DONE | frame in flight, waiting for tx_busy to fall
   // S_GAP     | forced idle between frames
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ISSUE     = 3'd1;
   localparam logic [2:0] S_WAIT_BUSY = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_GAP       = 3'd4;

   localparam logic [2:0]     S_AFTER  = (GAP_CYC > 0) ? S_GAP : S_IDLE;
   localparam int             ACW      = $clog2(ACK_TIMEOUT + 1);
   localparam int             GCW      = $clog2(GAP_CYC + 2);
   localparam logic [ACW-1:0] ACK_LOAD = ACW'(ACK_TIMEOUT - 1);
   localparam logic [GCW-1:0] GAP_LOAD = GCW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   logic [2:0]     state, state_nx;
   logic [IDW-1:0] rr_ptr, pick_id, cand;
   logic           pick_ok;
   logic           noack_set;
   logic [ACW-1:0] ack_cnt;
   logic [GCW-1:0] gap_cnt;

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int offs);
      int sum;
      sum = int'(base) + offs;
      if (sum >= NREQ) sum = sum - NREQ;
      return IDW'(sum);
   endfunction

   // First valid requester searching upward from rr_ptr with wrap.
   always_comb begin
      pick_ok = 1'b0;
      pick_id = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = wrap_add(rr_ptr, k);
         if (!pick_ok && req_valid[cand]) begin
            pick_ok = 1'b1;
            pick_id = cand;
         end
      end
`ifdef UART_SCHED_PRIO0_EN
      if (req_valid[0]) begin
         pick_ok = 1'b1;
         pick_id = '0;
      end
`endif
   end

   always_comb begin
      state_nx  = state;
      noack_set = 1'b0;
      case (state)
         S_IDLE:      if (pick_ok && !core_tx_busy) state_nx = S_ISSUE;
         S_ISSUE:     state_nx = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (core_tx_busy) begin
               state_nx = S_WAIT_DONE;
            end else if (ack_cnt == '0) begin
               noack_set = 1'b1;
               state_nx  = S_AFTER;
            end
         end
         S_WAIT_DONE: if (!core_tx_busy) state_nx = S_AFTER;
         S_GAP:       if (gap_cnt == '0) state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   // Strobes and grant flag are registered from the next state so they leave flops cleanly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         req_ready    <= '0;
         core_tx_req  <= 1'b0;
         core_tx_data <= '0;
         grant_active <= 1'b0;
         grant_id     <= '0;
         err_noack    <= 1'b0;
         ack_cnt      <= '0;
         gap_cnt      <= '0;
      end else begin
         state        <= state_nx;
         core_tx_req  <= (state_nx == S_ISSUE);
         req_ready    <= (state_nx == S_ISSUE) ? (NREQ'(1) << pick_id) : '0;
         grant_active <= (state_nx == S_ISSUE) || (state_nx == S_WAIT_BUSY) ||
                         (state_nx == S_WAIT_DONE);
         err_noack    <= noack_set | (err_noack & ~err_clr);

         if (state == S_IDLE && state_nx == S_ISSUE) begin
            core_tx_data <= req_data[8*pick_id +: 8];
            grant_id     <= pick_id;
         end

         if (state == S_ISSUE) begin
            ack_cnt <= ACK_LOAD;
`ifdef UART_SCHED_PRIO0_EN
            if (grant_id != '0) rr_ptr <= wrap_add(grant_id, 1);
`else
            rr_ptr <= wrap_add(grant_id, 1);
`endif
         end else if (state == S_WAIT_BUSY && ack_cnt != '0) begin
            ack_cnt <= ack_cnt - 1'b1;
         end

         if (state_nx == S_GAP && state != S_GAP) begin
            gap_cnt <= GAP_LOAD;
         end else if (state == S_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed vector table, corner sequences,
// and randomized requesters against a transaction-level arbitration model.
module tb_uart_tx_sched;

   localparam int NREQ        = 4;
   localparam int GAP_CYC     = 2;
   localparam int ACK_TIMEOUT = 8;
   localparam int NCYC        = 3000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  core_tx_data;
   logic        core_tx_req;
   logic        core_tx_busy;
   logic        grant_active;
   logic [1:0]  grant_id;
   logic        err_noack;
   logic        err_clr;

   int errors = 0;
   int checks = 0;

   // behavioural uart_core: busy from the cycle after tx_req for busy_len cycles
   int busy_left = 0;
   int busy_len  = 3;
   bit start_pend = 0, core_ack = 1, foreign_busy = 0, rand_len = 0, prev_busy = 0;
   int cyc = 0;
   int fall_cyc = -1;

   uart_tx_sched #(.NREQ(NREQ), .GAP_CYC(GAP_CYC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .core_tx_data(core_tx_data), .core_tx_req(core_tx_req),
      .core_tx_busy(core_tx_busy), .grant_active(grant_active), .grant_id(grant_id),
      .err_noack(err_noack), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [3:0] valid;
      logic [1:0] exp_id;
      logic [3:0] exp_ready;
      logic [7:0] exp_data;
   } vec_t;
   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (start_pend) begin
         busy_left  = rand_len ? int'($urandom_range(1, 6)) : busy_len;
         start_pend = 0;
      end
      core_tx_busy = (busy_left > 0) || foreign_busy;
      if (busy_left > 0) busy_left--;
      if (prev_busy && !core_tx_busy) fall_cyc = cyc;
      prev_busy = core_tx_busy;
      if (core_tx_req && core_ack) start_pend = 1;
   endtask

   task automatic wait_issue(input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!core_tx_req && n < max);
      check("issue_seen", 32'(core_tx_req), 32'd1);
   endtask

   task automatic clear_core();
      busy_left    = 0;
      start_pend   = 0;
      foreign_busy = 0;
      core_tx_busy = 1'b0;
      prev_busy    = 0;
      fall_cyc     = -1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      err_clr   = 1'b0;
      core_ack  = 1;
      clear_core();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Arbitration rule as stated: first valid index from the pointer, wrapping.
   function automatic int model_pick(input logic [3:0] v, input int rr);
      int idx;
`ifdef UART_SCHED_PRIO0_EN
      if (v[0]) return 0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         idx = (rr + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   initial begin
      int n, ga, pulses, g, model_rr, frames;
      logic [3:0]  vec_last;
      logic [31:0] data_last, sh;

`ifdef UART_SCHED_PRIO0_EN
      tbl[0]  = '{4'b1111, 2'd0, 4'b0001, 8'h10};
      tbl[1]  = '{4'b1111, 2'd0, 4'b0001, 8'h10};
      tbl[2]  = '{4'b1111, 2'd0, 4'b0001, 8'h10};
      tbl[3]  = '{4'b1111, 2'd0, 4'b0001, 8'h10};
      tbl[4]  = '{4'b1111, 2'd0, 4'b0001, 8'h10};
      tbl[5]  = '{4'b1010, 2'd1, 4'b0010, 8'h11};
      tbl[6]  = '{4'b1001, 2'd0, 4'b0001, 8'h10};
      tbl[7]  = '{4'b0110, 2'd2, 4'b0100, 8'h12};
      tbl[8]  = '{4'b0001, 2'd0, 4'b0001, 8'h10};
      tbl[9]  = '{4'b1100, 2'd3, 4'b1000, 8'h13};
      tbl[10] = '{4'b0011, 2'd0, 4'b0001, 8'h10};
      tbl[11] = '{4'b1000, 2'd3, 4'b1000, 8'h13};
`else
      tbl[0]  = '{4'b1111, 2'd0, 4'b0001, 8'h10};
      tbl[1]  = '{4'b1111, 2'd1, 4'b0010, 8'h11};
      tbl[2]  = '{4'b1111, 2'd2, 4'b0100, 8'h12};
      tbl[3]  = '{4'b1111, 2'd3, 4'b1000, 8'h13};
      tbl[4]  = '{4'b1111, 2'd0, 4'b0001, 8'h10};
      tbl[5]  = '{4'b1010, 2'd1, 4'b0010, 8'h11};
      tbl[6]  = '{4'b1001, 2'd3, 4'b1000, 8'h13};
      tbl[7]  = '{4'b0110, 2'd1, 4'b0010, 8'h11};
      tbl[8]  = '{4'b0001, 2'd0, 4'b0001, 8'h10};
      tbl[9]  = '{4'b1100, 2'd2, 4'b0100, 8'h12};
      tbl[10] = '{4'b0011, 2'd0, 4'b0001, 8'h10};
      tbl[11] = '{4'b1000, 2'd3, 4'b1000, 8'h13};
`endif

      req_data = 32'h1312_1110;
      do_reset();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_tx_req", 32'(core_tx_req), 32'd0);
      check("rst_tx_data", 32'(core_tx_data), 32'd0);
      check("rst_grant_active", 32'(grant_active), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_err", 32'(err_noack), 32'd0);

      // single byte from requester 2, 40-cycle frame
      busy_len  = 40;
      req_data  = 32'h13A5_1110;
      req_valid = 4'b0100;
      wait_issue(5, n);
      check("single_latency", 32'(n), 32'd1);
      check("single_id", 32'(grant_id), 32'd2);
      check("single_ready", 32'(req_ready), 32'b0100);
      check("single_data", 32'(core_tx_data), 32'hA5);
      check("single_active", 32'(grant_active), 32'd1);
      n  = 0;
      ga = 1;
      while (n < 100) begin
         tick();
         n++;
         if (core_tx_req) break;
         if (grant_active) ga++;
      end
      // 1 cycle to busy, busy_len busy, 1 to see it fall, GAP_CYC gap, 1 in IDLE
      check("single_regrant_dist", 32'(n), 32'(busy_len + GAP_CYC + 3));
      check("single_active_len", 32'(ga), 32'(busy_len + 2));

      // vector table
      do_reset();
      busy_len = 3;
      req_data = 32'h1312_1110;
      for (int i = 0; i < 12; i++) begin
         req_valid = tbl[i].valid;
         wait_issue(80, n);
         check($sformatf("tbl%0d_id", i), 32'(grant_id), 32'(tbl[i].exp_id));
         check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
         check($sformatf("tbl%0d_data", i), 32'(core_tx_data), 32'(tbl[i].exp_data));
         check($sformatf("tbl%0d_no_overlap", i), 32'(core_tx_busy), 32'd0);
         tick();
         check($sformatf("tbl%0d_one_pulse", i), 32'(core_tx_req), 32'd0);
      end

      // core never acknowledges
      do_reset();
      core_ack  = 0;
      req_valid = 4'b0001;
      wait_issue(10, n);
      repeat (ACK_TIMEOUT) tick();
      check("noack_early", 32'(err_noack), 32'd0);
      tick();
      check("noack_set", 32'(err_noack), 32'd1);
      check("noack_gap_inactive", 32'(grant_active), 32'd0);
      wait_issue(20, n);
      check("noack_regrant_lat", 32'(n), 32'(GAP_CYC + 1));
      check("noack_sticky", 32'(err_noack), 32'd1);
      req_valid = 4'b0000;
      tick();
      tick();
      err_clr = 1'b1;
      tick();
      check("err_clr", 32'(err_noack), 32'd0);
      err_clr = 1'b0;
      repeat (ACK_TIMEOUT - 3) tick();
      err_clr = 1'b1;
      tick();
      check("clr_vs_set", 32'(err_noack), 32'd1);
      err_clr  = 1'b0;
      core_ack = 1;

      // foreign busy blocks the grant
      do_reset();
      foreign_busy = 1;
      core_tx_busy = 1'b1;
      prev_busy    = 1;
      req_valid    = 4'b0010;
      pulses       = 0;
      repeat (10) begin
         tick();
         if (core_tx_req) pulses++;
      end
      check("foreign_no_grant", 32'(pulses), 32'd0);
      foreign_busy = 0;
      core_tx_busy = 1'b0;
      wait_issue(10, n);
      check("foreign_latency", 32'(n), 32'd1);
      check("foreign_id", 32'(grant_id), 32'd1);

      // reset asserted mid-frame
      do_reset();
      busy_len  = 20;
      req_valid = 4'b0100;
      wait_issue(5, n);
      req_valid = 4'b0000;
      repeat (5) tick();
      check("pre_rst_active", 32'(grant_active), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_ready", 32'(req_ready), 32'd0);
      check("arst_tx_req", 32'(core_tx_req), 32'd0);
      check("arst_tx_data", 32'(core_tx_data), 32'd0);
      check("arst_active", 32'(grant_active), 32'd0);
      check("arst_grant_id", 32'(grant_id), 32'd0);
      clear_core();
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      busy_len  = 3;
      req_valid = 4'b1111;
      wait_issue(5, n);
      check("post_rst_first_id", 32'(grant_id), 32'd0);

`ifdef UART_SCHED_PRIO0_EN
      do_reset();
      req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_issue(40, n);
         check($sformatf("prio_hold%0d", k), 32'(grant_id), 32'd0);
      end
      req_valid = 4'b1110;
      for (int k = 1; k < 4; k++) begin
         wait_issue(40, n);
         check($sformatf("prio_rr%0d", k), 32'(grant_id), 32'(k));
      end
`endif

      // randomized requesters against the arbitration model
      do_reset();
      rand_len  = 1;
      model_rr  = 0;
      frames    = 0;
      vec_last  = '0;
      data_last = req_data;
      for (int c = 0; c < NCYC; c++) begin
         tick();
         if (core_tx_req) begin
            g = model_pick(vec_last, model_rr);
            if (g < 0) begin
               check("rnd_spurious_grant", 32'(req_ready), 32'd0);
            end else begin
               sh = data_last >> (8 * g);
               check("rnd_id", 32'(grant_id), 32'(g));
               check("rnd_ready", 32'(req_ready), 32'(4'b0001 << g));
               check("rnd_data", 32'(core_tx_data), 32'(sh[7:0]));
`ifdef UART_SCHED_PRIO0_EN
               if (g != 0) model_rr = (g + 1) % NREQ;
`else
               model_rr = (g + 1) % NREQ;
`endif
            end
            check("rnd_no_overlap", 32'(core_tx_busy), 32'd0);
            if (fall_cyc >= 0)
               check("rnd_gap", 32'((cyc - fall_cyc) >= GAP_CYC + 2), 32'd1);
            frames++;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
               if (c < NCYC - 200 && $urandom_range(0, 1) == 1) begin
                  req_data[8*i +: 8] = 8'($urandom);
               end else begin
                  req_valid[i] = 1'b0;
               end
            end else if (!req_valid[i] && c < NCYC - 200 && $urandom_range(0, 3) == 0) begin
               req_data[8*i +: 8] = 8'($urandom);
               req_valid[i]       = 1'b1;
            end
         end
         vec_last  = req_valid;
         data_last = req_data;
      end
      check("rnd_drained", 32'(req_valid), 32'd0);
      check("rnd_activity", 32'(frames > 50), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
